fifo_dpram_ctrl: RTL and testbench
==================================

FIFO_DPRAM_CTRL -- requirements
Module: fifo_dpram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM address width; depth = 2**ADDR_WIDTH (64).
REQ-003 SHALL have parameter AF_THRESH, default 60, almost_full asserted when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 4, almost_empty asserted when count <= AE_THRESH.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, ports clk and reset_L.
REQ-006 Ports SHALL be, in this order:
- clk  in  1  clock, all logic on rising edge
- reset_L  in  1  async active-low reset
- push  in  1  write request
- data_in  in  DATA_WIDTH  write data
- pop  in  1  read request
- data_out  out  DATA_WIDTH  read data, qualified by valid_out
- valid_out  out  1  data_out valid this cycle
- full  out  1  count == depth
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- fifo_count  out  ADDR_WIDTH+1  current occupancy
- err_ovf  out  1  sticky overflow flag
- err_udf  out  1  sticky underflow flag
- ram_addr_a  out  ADDR_WIDTH  RAM port A address (write)
- ram_data_a  out  DATA_WIDTH  RAM port A write data
- ram_we_a  out  1  RAM port A write enable
- ram_addr_b  out  ADDR_WIDTH  RAM port B address (read)
- ram_data_b  out  DATA_WIDTH  RAM port B write data, constant 0
- ram_we_b  out  1  RAM port B write enable, constant 0
- ram_q_b  in  DATA_WIDTH  RAM port B registered read data

Function
REQ-007 Block SHALL drive the external single-clock dual-port RAM: port A write-only, port B read-only.
REQ-008 ram_addr_a/ram_data_a/ram_we_a SHALL be combinational: wr_ptr, data_in, push accepted.
REQ-009 ram_addr_b SHALL be rd_ptr combinationally; pop accepted advances rd_ptr next edge.
REQ-010 Push accepted iff push=1 and full=0; wr_ptr increments modulo depth (63 -> 0 wrap).
REQ-011 Pop accepted iff pop=1 and empty=0; rd_ptr increments modulo depth.
REQ-012 Read latency SHALL be 1 cycle: pop accepted at edge N -> valid_out=1 and data_out=ram_q_b during cycle N+1.
REQ-013 data_out SHALL pass ram_q_b through; value undefined-but-held when valid_out=0.
REQ-014 fifo_count SHALL update next edge: +1 push only, -1 pop only, unchanged both or neither.
REQ-015 Simultaneous push+pop when empty: push accepted, pop rejected, underflow raised.
REQ-016 Simultaneous push+pop when full: pop accepted, push rejected, overflow raised.
REQ-017 Simultaneous push+pop otherwise: both accepted, count unchanged.
REQ-018 FSM states EMPTY, ACTIVE, FULL; EMPTY->ACTIVE on accepted push; ACTIVE->EMPTY when count goes 1->0; ACTIVE->FULL when count goes depth-1->depth; FULL->ACTIVE on accepted pop.
REQ-019 full, empty, almost_full, almost_empty SHALL be registered, consistent with fifo_count same cycle.

Reset
REQ-020 reset_L low SHALL immediately clear wr_ptr, rd_ptr, fifo_count, valid_out, err_ovf, err_udf to 0, set state EMPTY, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-021 Reset mid-operation SHALL discard contents logically; RAM contents not cleared.
REQ-022 No push/pop SHALL be accepted on the first edge where reset_L deasserts.

Configuration
REQ-023 Macro FIFO_ERR_FLAGS_EN defined: err_ovf set on rejected push, err_udf set on rejected pop, sticky until reset.
REQ-024 Macro FIFO_ERR_FLAGS_EN undefined: err_ovf and err_udf tied 0; all other behaviour identical.

Verification
REQ-025 Reset, push 0x11,0x22,0x33, then pop x3 -> data_out 0x11,0x22,0x33, each 1 cycle after pop, fifo_count 3->0, empty=1.
REQ-026 Push 64 words -> full=1, fifo_count=64; extra push 0xAA -> count stays 64, err_ovf=1 (macro on) or 0 (off).
REQ-027 Pop when empty -> valid_out=0, rd_ptr unchanged, err_udf=1 with macro.
REQ-028 Fill 40, hold push+pop 100 cycles with incrementing data -> count stays 40, pointers wrap past 63, data order preserved.
REQ-029 Fill 60 -> almost_full=1; pop to 4 -> almost_empty=1; reset_L low mid-stream -> all outputs per REQ-020 without clock edge.

Source files
------------

// File: rtl/fifo_dpram_ctrl.sv
// fifo_dpram_ctrl: FIFO controller for an external 1-clock dual-port RAM (A write, B read); FIFO_ERR_FLAGS_EN enables sticky err_ovf/err_udf
module fifo_dpram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_THRESH  = 60,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  err_ovf,
    output logic                  err_udf,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C  = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C  = AE_THRESH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  valid_q, full_q, empty_q, af_q, ae_q;
    logic                  en_q;
    logic                  push_ok, pop_ok;

    // en_q stays low through the first edge after reset release so nothing is accepted on it
    assign push_ok = en_q & push & ~full_q;
    assign pop_ok  = en_q & pop & ~empty_q;
    assign cnt_d   = (push_ok && !pop_ok) ? cnt_q + 1'b1 :
                     (pop_ok && !push_ok) ? cnt_q - 1'b1 : cnt_q;

    assign ram_addr_a   = wr_ptr_q;
    assign ram_data_a   = data_in;
    assign ram_we_a     = push_ok;
    assign ram_addr_b   = rd_ptr_q;
    assign ram_data_b   = '0;
    assign ram_we_b     = 1'b0;
    assign data_out     = ram_q_b;
    assign valid_out    = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign fifo_count   = cnt_q;

    // Pointers, occupancy and status flags; flags are registered from the next count so they match fifo_count
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            en_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            en_q     <= 1'b1;
            wr_ptr_q <= push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
            cnt_q    <= cnt_d;
            valid_q  <= pop_ok;
            full_q   <= cnt_d == DEPTH;
            empty_q  <= cnt_d == '0;
            af_q     <= cnt_d >= AF_C;
            ae_q     <= cnt_d <= AE_C;
        end
    end

    // Occupancy state machine: EMPTY / ACTIVE / FULL
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:  state_q <= push_ok ? ST_ACTIVE : ST_EMPTY;
                ST_ACTIVE: state_q <= (cnt_d == '0) ? ST_EMPTY : (cnt_d == DEPTH) ? ST_FULL : ST_ACTIVE;
                ST_FULL:   state_q <= pop_ok ? ST_ACTIVE : ST_FULL;
                default:   state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;
    // Sticky error flags: a rejected push sets overflow, a rejected pop sets underflow
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (en_q & push & full_q);
            udf_q <= udf_q | (en_q & pop & empty_q);
        end
    end
    assign err_ovf = ovf_q;
    assign err_udf = udf_q;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// tb_fifo_dpram_ctrl: directed scoreboard bench for fifo_dpram_ctrl with a behavioural dual-port RAM
module tb_fifo_dpram_ctrl;
    logic       clk = 1'b0;
    logic       reset_L, push, pop;
    logic [7:0] data_in, data_out, ram_data_a, ram_data_b, ram_q_b;
    logic       valid_out, full, empty, almost_full, almost_empty, err_ovf, err_udf;
    logic [6:0] fifo_count;
    logic [5:0] ram_addr_a, ram_addr_b;
    logic       ram_we_a, ram_we_b;
    logic [7:0] mem [64];

    logic [7:0] sb [$];
    int         mcnt, n_cmp, n_bad;
    logic [5:0] mwr, mrd;
    logic       movf, mudf;

    fifo_dpram_ctrl dut (
        .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .fifo_count(fifo_count),
        .err_ovf(err_ovf), .err_udf(err_udf),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b),
        .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk_status();
        chk("fifo_count", 32'(fifo_count), 32'(mcnt));
        chk("full", 32'(full), 32'(mcnt == 64));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= 60));
        chk("almost_empty", 32'(almost_empty), 32'(mcnt <= 4));
        chk("err_ovf", 32'(err_ovf), 32'(movf));
        chk("err_udf", 32'(err_udf), 32'(mudf));
        chk("ram_addr_a", 32'(ram_addr_a), 32'(mwr));
        chk("ram_addr_b", 32'(ram_addr_b), 32'(mrd));
    endtask

    task automatic cycle(input logic p, input logic [7:0] d, input logic q);
        logic       pa, qa;
        logic [7:0] e;
        e = 8'h00;
        push = p; data_in = d; pop = q;
        pa = p && mcnt != 64;
        qa = q && mcnt != 0;
`ifdef FIFO_ERR_FLAGS_EN
        if (p && !pa) movf = 1'b1;
        if (q && !qa) mudf = 1'b1;
`endif
        #1;
        chk("ram_we_a", 32'(ram_we_a), 32'(pa));
        if (pa) chk("ram_data_a", 32'(ram_data_a), 32'(d));
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
        if (qa) begin e = sb.pop_front(); mrd++; end
        if (pa) begin sb.push_back(d); mwr++; end
        mcnt = sb.size();
        chk("valid_out", 32'(valid_out), 32'(qa));
        if (qa) chk("data_out", 32'(data_out), 32'(e));
        chk_status();
    endtask

    task automatic do_reset();
        #2 reset_L = 1'b0;
        #1;
        sb.delete(); mcnt = 0; mwr = '0; mrd = '0; movf = 1'b0; mudf = 1'b0;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ram_we_b", 32'(ram_we_b), 32'd0);
        chk("rst_ram_data_b", 32'(ram_data_b), 32'd0);
        chk_status();
        @(posedge clk); #1;
        reset_L = 1'b1; push = 1'b1; data_in = 8'h5A;
        #1;
        chk("first_edge_we", 32'(ram_we_a), 32'd0);
        @(posedge clk); #1;
        push = 1'b0;
        chk("first_edge_valid", 32'(valid_out), 32'd0);
        chk_status();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_L = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        mcnt = 0; mwr = '0; mrd = '0; movf = 1'b0; mudf = 1'b0;
        @(posedge clk); #1;
        do_reset();
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b1);
        cycle(1'b1, 8'hCC, 1'b0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hDD, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'(40 + i), 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(140 + i), 1'b0);
        for (int i = 0; i < 56; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hE1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        do_reset();
        cycle(1'b1, 8'h42, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
